alu_cmp_sequencer: RTL

//  Decode-and-issue side of the LUI/SLT datapath. Accepts one MIPS instruction per

---
 rtl/alu_cmp_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_cmp_sequencer.sv
// Decode-and-issue sequencer for the LUI/SLT unit: decodes one MIPS instruction at a time,
// reads rs/rt from a sync-read regfile, drives the unit, and writes the result back.
module alu_cmp_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_aluc,
  input  logic [31:0]      alu_r,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // Handshake: an instruction is taken on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and the source holds in_valid/in_instr until taken.
  typedef enum logic [2:0] {IDLE, RD, EX, WB, ERR} state_t;
  state_t state;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        dec_legal;
  logic        dec_lui;
  logic        dec_imm;
  logic [1:0]  dec_aluc;
  logic [4:0]  dec_dst;

  logic        lui_q;
  logic        imm_sel_q;
  logic [1:0]  aluc_q;
  logic [4:0]  dst_q;
  logic [15:0] imm_q;

  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [1:0]  alu_aluc_q;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        unused_shamt;

  assign op           = in_instr[31:26];
  assign funct        = in_instr[5:0];
  assign unused_shamt = ^in_instr[10:6];

  always_comb begin
    dec_legal = 1'b0;
    dec_lui   = 1'b0;
    dec_imm   = 1'b0;
    dec_aluc  = 2'b00;
    dec_dst   = in_instr[20:16];
    case (op)
      6'b001111: begin dec_legal = 1'b1; dec_lui = 1'b1; dec_imm = 1'b1; dec_aluc = 2'b00; end
      6'b001010: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_aluc = 2'b11; end
      6'b001011: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_aluc = 2'b10; end
      6'b000000: begin
        dec_dst = in_instr[15:11];
        if (funct == 6'b101010) begin
          dec_legal = 1'b1;
          dec_aluc  = 2'b11;
        end else if (funct == 6'b101011) begin
          dec_legal = 1'b1;
          dec_aluc  = 2'b10;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Regfile data only arrives during EX, so the operands are steered combinationally
  // there and frozen into the hold registers as EX ends.
  assign ex_a = lui_q ? 32'd0 : rf_rdata1;
  assign ex_b = lui_q     ? {16'd0, imm_q} :
                imm_sel_q ? {{16{imm_q[15]}}, imm_q} : rf_rdata2;

  assign alu_a    = (state == EX) ? ex_a   : alu_a_q;
  assign alu_b    = (state == EX) ? ex_b   : alu_b_q;
  assign alu_aluc = (state == EX) ? aluc_q : alu_aluc_q;
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rf_we      <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      retired    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_aluc_q <= '0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      rf_raddr1  <= '0;
      rf_raddr2  <= '0;
      lui_q      <= 1'b0;
      imm_sel_q  <= 1'b0;
      aluc_q     <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
    end else begin
      rf_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            lui_q     <= dec_lui;
            imm_sel_q <= dec_imm;
            aluc_q    <= dec_aluc;
            dst_q     <= dec_dst;
            imm_q     <= in_instr[15:0];
            rf_raddr1 <= in_instr[25:21];
            rf_raddr2 <= in_instr[20:16];
            illegal   <= ~dec_legal;
            state     <= dec_legal ? RD : ERR;
          end
        end
        RD: state <= EX;
        EX: begin
          alu_a_q    <= ex_a;
          alu_b_q    <= ex_b;
          alu_aluc_q <= aluc_q;
          rf_wdata   <= alu_r;
          rf_waddr   <= dst_q;
          rf_we      <= (dst_q != 5'd0);
          done       <= 1'b1;
          retired    <= retired + CNT_W'(1);
          state      <= WB;
        end
        WB:      state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
